line_follow_ctrl: RTL and testbench
===================================

// Module: line_follow_ctrl
// PURPOSE
//  Parametrised line-follow controller for the TI-RSLK-MAX chassis: N-channel IR, calibrated threshold,
//  proportional steering, lost-line search with timeout, bump stop. Sits between IRcontrol
//  (ttd bus in) and the two pwm/motor driver instances (speed/dir/drive out) in fpga_top.
//  Replaces the fixed 8-channel bang-bang follower with a registered, width/count-generic design.
// PARAMETERS
//  NUM_CH        8      IR channels; even, >=4. Channel 0 = robot's far right, NUM_CH-1 = far left
//  TTD_W         17     width of each time-to-discharge value
//  SPD_W         16     pwm on-time width
//  NUM_BUMP      6      bump switches (active-low)
//  BASE_SPEED    3200   straight-line on-time (20%)
//  MAX_SPEED     8000   steering clamp ceiling (50%)
//  TURN_STEP     800    on-time change per unit position error
//  SEARCH_SPEED  1600   spin-in-place on-time (10%)
//  MARGIN        10     detection slack below black threshold
//  CAL_SAMPLES   16     ttd sample sets folded into calibration
//  LOST_TICKS    2000   ticks in SEARCH before giving up (1 s at 0.5 ms tick)
// PORTS
//  WF_CLK        in   1              system clock
//  WF_RST_N      in   1              reset, asynchronous, active-low
//  tick          in   1              one-cycle 0.5 ms strobe
//  start         in   1              one-cycle run request (synchronised upstream)
//  cal_req       in   1              one-cycle calibrate request
//  bump_n        in   NUM_BUMP       bump switches, 0 = pressed
//  ttd           in   NUM_CH*TTD_W   flat ttd bus, channel i at [i*TTD_W +: TTD_W]
//  ttd_valid     in   1              one-cycle strobe: ttd holds a fresh sample set
//  ch_sel        out  NUM_CH         IR channel enables
//  motor_en      out  1              driver enable, both sides
//  motorL_drive/motorR_drive  out 1  pwm run
//  motorL_dir/motorR_dir      out 1  0 = forward, 1 = reverse
//  motorL_speed/motorR_speed  out SPD_W  pwm on-time
//  line_view     out  NUM_CH         registered per-channel black detect
//  black_thresh  out  TTD_W          calibrated threshold
//  state         out  3              current FSM state (debug LEDs)
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; thresh, counters, last_dir cleared.
//  Detect: on ttd_valid, line_view[i] <= (ttd_i + MARGIN >= thresh), computed at TTD_W+1 bits (no underflow).
//   Holds between strobes. Latency: 1 cycle from ttd_valid.
//  Error: err = lmost + rmost - (NUM_CH-1), signed, using highest/lowest set line_view bits; registered with
//   speeds 1 cycle after line_view updates (2 cycles from ttd_valid). err>0 = line left of centre.
//  Steering (FOLLOW): L = BASE - err*TURN_STEP, R = BASE + err*TURN_STEP, signed math, clamped [0,MAX_SPEED].
//   last_dir <= (err>=0) whenever line_view != 0.
//  FSM (priority top-down within a state):
//   IDLE   en=0 drive=0 ch_sel=0.            cal_req -> CAL
//   CAL    en=1 drive=0 ch_sel=all. Entry clears thresh; each ttd_valid: thresh <= max(thresh, all ttd_i);
//          after CAL_SAMPLES strobes -> ARMED. start/bump ignored.
//   ARMED  en=1 drive=0. cal_req -> CAL; start with all bump_n=1 -> SEEK; start while bumped ignored.
//   SEEK   both fwd BASE_SPEED; ch_sel = centre bits NUM_CH/2-1, NUM_CH/2 only. any bump -> STOP;
//          line_view != 0 -> FOLLOW.
//   FOLLOW ch_sel=all, fwd, steering. any bump -> STOP; line_view == 0 -> SEARCH (clear tick count).
//   SEARCH spin at SEARCH_SPEED: last_dir=1 -> L rev/R fwd, else L fwd/R rev. any bump -> STOP;
//          line_view != 0 -> FOLLOW; tick count == LOST_TICKS -> STOP.
//   STOP   en=1 drive=0, speeds hold BASE. cal_req -> CAL; start with no bump -> SEEK.
//  Simultaneous: bump beats line/timeout; cal_req beats start; cal_req ignored in SEEK/FOLLOW/SEARCH.
//  Reset mid-run: motors off within 0 cycles (async), threshold lost, recalibration required.
// TESTING
//  1 Reset, cal_req, 16 sets with peak ttd 5000 on ch5 -> black_thresh=5000, state ARMED after 16th strobe.
//  2 thresh=5000, start, ch3/ch4 ttd=4995 -> SEEK->FOLLOW; err=0; L=R=3200, both dir=0.
//  3 FOLLOW, line on ch6 only -> err=5; L=0 (clamped), R=7200, 2 cycles after ttd_valid.
//  4 FOLLOW, line lost after err>0 -> SEARCH, L rev/R fwd at 1600; 2000 ticks no line -> STOP, drive=0.
//  5 FOLLOW, bump_n[2]=0 same cycle line moves -> STOP; start while bump held -> stays STOP.
//  6 WF_RST_N low mid-FOLLOW -> all outputs 0 immediately; ttd 4999 vs MARGIN 10, thresh 5000 -> detect=1.

Source files
------------

// File: rtl/line_follow_ctrl.sv
// Line-follow controller: IR threshold calibration, black-line detection,
// proportional steering, timed lost-line search and bump stop.
module line_follow_ctrl #(
  parameter int NUM_CH       = 8,
  parameter int TTD_W        = 17,
  parameter int SPD_W        = 16,
  parameter int NUM_BUMP     = 6,
  parameter int BASE_SPEED   = 3200,
  parameter int MAX_SPEED    = 8000,
  parameter int TURN_STEP    = 800,
  parameter int SEARCH_SPEED = 1600,
  parameter int MARGIN       = 10,
  parameter int CAL_SAMPLES  = 16,
  parameter int LOST_TICKS   = 2000
) (
  input  logic                    WF_CLK,
  input  logic                    WF_RST_N,
  input  logic                    tick,
  input  logic                    start,
  input  logic                    cal_req,
  input  logic [NUM_BUMP-1:0]     bump_n,
  input  logic [NUM_CH*TTD_W-1:0] ttd,
  input  logic                    ttd_valid,
  output logic [NUM_CH-1:0]       ch_sel,
  output logic                    motor_en,
  output logic                    motorL_drive,
  output logic                    motorR_drive,
  output logic                    motorL_dir,
  output logic                    motorR_dir,
  output logic [SPD_W-1:0]        motorL_speed,
  output logic [SPD_W-1:0]        motorR_speed,
  output logic [NUM_CH-1:0]       line_view,
  output logic [TTD_W-1:0]        black_thresh,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CAL    = 3'd1,
    ST_ARMED  = 3'd2,
    ST_SEEK   = 3'd3,
    ST_FOLLOW = 3'd4,
    ST_SEARCH = 3'd5,
    ST_STOP   = 3'd6
  } state_e;

  localparam int CAL_W  = $clog2(CAL_SAMPLES + 1);
  localparam int TICK_W = $clog2(LOST_TICKS + 1);

  localparam logic [NUM_CH-1:0] CH_ALL    = '1;
  localparam logic [NUM_CH-1:0] CH_CENTRE = NUM_CH'(3) << (NUM_CH / 2 - 1);
  localparam logic [TTD_W:0]    MARGIN_X  = (TTD_W + 1)'(MARGIN);

  state_e             state_q, state_d;
  logic [TTD_W-1:0]   thresh_q, thresh_d;
  logic [CAL_W-1:0]   cal_cnt_q, cal_cnt_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic               last_dir_q, last_dir_d;
  logic [SPD_W-1:0]   spd_l_q, spd_l_d;
  logic [SPD_W-1:0]   spd_r_q, spd_r_d;
  logic [NUM_CH-1:0]  line_view_q, line_view_d;

  logic [TTD_W-1:0]   ttd_max;
  logic               any_bump;
  logic               line_seen;
  int                 err;
  logic [SPD_W-1:0]   steer_l;
  logic [SPD_W-1:0]   steer_r;

  function automatic logic [SPD_W-1:0] clamp_spd(input int v);
    if (v < 0)              return '0;
    else if (v > MAX_SPEED) return SPD_W'(MAX_SPEED);
    else                    return SPD_W'(v);
  endfunction

  assign any_bump  = ~&bump_n;
  assign line_seen = |line_view_q;

  // Per-channel detect (one bit wider so ttd + MARGIN never wraps) and sample-set peak.
  always_comb begin
    logic [TTD_W-1:0] ch_val;
    // NOTE: blocking assignments here build combinational temporaries; a
    // default on every output first guarantees no latch is inferred.
    line_view_d = line_view_q;
    ttd_max     = '0;
    ch_val      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_val = ttd[i*TTD_W +: TTD_W];
      if (ch_val > ttd_max) ttd_max = ch_val;
      if (ttd_valid) line_view_d[i] = ({1'b0, ch_val} + MARGIN_X) >= {1'b0, thresh_q};
    end
  end

  // Position error from the outermost detecting channels; positive = line to the left.
  always_comb begin
    int  lmost;
    int  rmost;
    logic found;
    lmost = 0;
    rmost = 0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (line_view_q[i]) begin
        if (!found) rmost = i;
        lmost = i;
        found = 1'b1;
      end
    end
    err     = lmost + rmost - (NUM_CH - 1);
    steer_l = clamp_spd(BASE_SPEED - err * TURN_STEP);
    steer_r = clamp_spd(BASE_SPEED + err * TURN_STEP);
  end

  always_comb begin
    state_d      = state_q;
    thresh_d     = thresh_q;
    cal_cnt_d    = cal_cnt_q;
    tick_cnt_d   = tick_cnt_q;
    last_dir_d   = last_dir_q;
    spd_l_d      = spd_l_q;
    spd_r_d      = spd_r_q;
    ch_sel       = '0;
    motor_en     = 1'b0;
    motorL_drive = 1'b0;
    motorR_drive = 1'b0;
    motorL_dir   = 1'b0;
    motorR_dir   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        spd_l_d = '0;
        spd_r_d = '0;
        if (cal_req) begin
          state_d   = ST_CAL;
          thresh_d  = '0;
          cal_cnt_d = '0;
        end
      end

      ST_CAL: begin
        motor_en = 1'b1;
        ch_sel   = CH_ALL;
        spd_l_d  = '0;
        spd_r_d  = '0;
        if (ttd_valid) begin
          if (ttd_max > thresh_q) thresh_d = ttd_max;
          if (cal_cnt_q == CAL_W'(CAL_SAMPLES - 1)) state_d = ST_ARMED;
          else                                      cal_cnt_d = cal_cnt_q + 1'b1;
        end
      end

      ST_ARMED: begin
        motor_en = 1'b1;
        ch_sel   = CH_ALL;
        spd_l_d  = '0;
        spd_r_d  = '0;
        if (cal_req) begin
          state_d   = ST_CAL;
          thresh_d  = '0;
          cal_cnt_d = '0;
        end else if (start && !any_bump) begin
          state_d = ST_SEEK;
        end
      end

      ST_SEEK: begin
        motor_en     = 1'b1;
        motorL_drive = 1'b1;
        motorR_drive = 1'b1;
        ch_sel       = CH_CENTRE;
        spd_l_d      = SPD_W'(BASE_SPEED);
        spd_r_d      = SPD_W'(BASE_SPEED);
        if (any_bump)       state_d = ST_STOP;
        else if (line_seen) state_d = ST_FOLLOW;
      end

      ST_FOLLOW: begin
        motor_en     = 1'b1;
        motorL_drive = 1'b1;
        motorR_drive = 1'b1;
        ch_sel       = CH_ALL;
        // With no line there is no meaningful error, so the last steering holds.
        if (line_seen) begin
          spd_l_d    = steer_l;
          spd_r_d    = steer_r;
          last_dir_d = (err >= 0);
        end
        if (any_bump) begin
          state_d = ST_STOP;
        end else if (!line_seen) begin
          state_d    = ST_SEARCH;
          tick_cnt_d = '0;
        end
      end

      ST_SEARCH: begin
        motor_en     = 1'b1;
        motorL_drive = 1'b1;
        motorR_drive = 1'b1;
        ch_sel       = CH_ALL;
        motorL_dir   = last_dir_q;
        motorR_dir   = ~last_dir_q;
        spd_l_d      = SPD_W'(SEARCH_SPEED);
        spd_r_d      = SPD_W'(SEARCH_SPEED);
        if (tick && tick_cnt_q != TICK_W'(LOST_TICKS)) tick_cnt_d = tick_cnt_q + 1'b1;
        if (any_bump)                                  state_d = ST_STOP;
        else if (line_seen)                            state_d = ST_FOLLOW;
        else if (tick_cnt_q == TICK_W'(LOST_TICKS))    state_d = ST_STOP;
      end

      ST_STOP: begin
        motor_en = 1'b1;
        ch_sel   = CH_ALL;
        spd_l_d  = SPD_W'(BASE_SPEED);
        spd_r_d  = SPD_W'(BASE_SPEED);
        if (cal_req) begin
          state_d   = ST_CAL;
          thresh_d  = '0;
          cal_cnt_d = '0;
        end else if (start && !any_bump) begin
          state_d = ST_SEEK;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge WF_CLK or negedge WF_RST_N) begin
    if (!WF_RST_N) begin
      state_q     <= ST_IDLE;
      thresh_q    <= '0;
      cal_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      last_dir_q  <= 1'b0;
      spd_l_q     <= '0;
      spd_r_q     <= '0;
      line_view_q <= '0;
    end else begin
      state_q     <= state_d;
      thresh_q    <= thresh_d;
      cal_cnt_q   <= cal_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      last_dir_q  <= last_dir_d;
      spd_l_q     <= spd_l_d;
      spd_r_q     <= spd_r_d;
      line_view_q <= line_view_d;
    end
  end

  assign motorL_speed = spd_l_q;
  assign motorR_speed = spd_r_q;
  assign line_view    = line_view_q;
  assign black_thresh = thresh_q;
  assign state        = state_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Scoreboard bench for line_follow_ctrl: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_line_follow_ctrl;

  localparam int NCH = 8;
  localparam int TW  = 17;

  localparam int S_IDLE = 0, S_CAL = 1, S_ARMED = 2, S_SEEK = 3,
                 S_FOLLOW = 4, S_SEARCH = 5, S_STOP = 6;

  typedef enum {K_STATE, K_EN, K_DRIVE, K_DIR_L, K_DIR_R,
                K_SPD_L, K_SPD_R, K_CHSEL, K_LV, K_THR} kind_e;

  typedef struct {
    int    cyc;
    kind_e kind;
    int    val;
    string name;
  } exp_t;

  logic              WF_CLK = 1'b0;
  logic              WF_RST_N;
  logic              tick, start, cal_req, ttd_valid;
  logic [5:0]        bump_n;
  logic [NCH*TW-1:0] ttd;
  logic [NCH-1:0]    ch_sel, line_view;
  logic              motor_en, motorL_drive, motorR_drive, motorL_dir, motorR_dir;
  logic [15:0]       motorL_speed, motorR_speed;
  logic [TW-1:0]     black_thresh;
  logic [2:0]        state;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  line_follow_ctrl dut (
    .WF_CLK       (WF_CLK),
    .WF_RST_N     (WF_RST_N),
    .tick         (tick),
    .start        (start),
    .cal_req      (cal_req),
    .bump_n       (bump_n),
    .ttd          (ttd),
    .ttd_valid    (ttd_valid),
    .ch_sel       (ch_sel),
    .motor_en     (motor_en),
    .motorL_drive (motorL_drive),
    .motorR_drive (motorR_drive),
    .motorL_dir   (motorL_dir),
    .motorR_dir   (motorR_dir),
    .motorL_speed (motorL_speed),
    .motorR_speed (motorR_speed),
    .line_view    (line_view),
    .black_thresh (black_thresh),
    .state        (state)
  );

  always #5 WF_CLK = ~WF_CLK;

  task automatic check(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic int actual(input kind_e k);
    case (k)
      K_STATE: return int'(state);
      K_EN:    return int'(motor_en);
      K_DRIVE: return int'({motorL_drive, motorR_drive});
      K_DIR_L: return int'(motorL_dir);
      K_DIR_R: return int'(motorR_dir);
      K_SPD_L: return int'(motorL_speed);
      K_SPD_R: return int'(motorR_speed);
      K_CHSEL: return int'(ch_sel);
      K_LV:    return int'(line_view);
      K_THR:   return int'(black_thresh);
      default: return -1;
    endcase
  endfunction

  // Expectation due at the negedge following n further rising edges.
  task automatic expect_in(input int n, input kind_e k, input int v, input string nm);
    exp_t e;
    e.cyc  = cyc + n + 1;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge WF_CLK);
    #1;
  endtask

  function automatic logic [NCH*TW-1:0] mk(input logic [NCH-1:0] mask, input int val);
    logic [NCH*TW-1:0] b;
    b = '0;
    for (int i = 0; i < NCH; i++)
      if (mask[i]) b[i*TW +: TW] = TW'(val);
    return b;
  endfunction

  task automatic send(input logic [NCH*TW-1:0] b);
    ttd       = b;
    ttd_valid = 1'b1;
    step(1);
    ttd_valid = 1'b0;
  endtask

  // Monitor: compare every expectation that has come due.
  initial begin
    forever begin
      @(negedge WF_CLK);
      cyc++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= cyc) begin
          check(sb[i].name, actual(sb[i].kind), sb[i].val);
          sb.delete(i);
        end
      end
    end
  end

  typedef struct {
    logic [NCH-1:0] mask;
    int             l;
    int             r;
  } steer_t;

  initial begin
    steer_t tbl[5];
    logic [NCH*TW-1:0] b;
    int prev_l, prev_r, peak;

    WF_RST_N  = 1'b0;
    tick      = 1'b0;
    start     = 1'b0;
    cal_req   = 1'b0;
    ttd_valid = 1'b0;
    bump_n    = '1;
    ttd       = '0;
    expect_in(0, K_STATE, S_IDLE, "rst_state");
    expect_in(0, K_EN,    0,      "rst_en");
    expect_in(0, K_DRIVE, 0,      "rst_drive");
    expect_in(0, K_SPD_L, 0,      "rst_spd_l");
    expect_in(0, K_SPD_R, 0,      "rst_spd_r");
    expect_in(0, K_CHSEL, 0,      "rst_chsel");
    expect_in(0, K_LV,    0,      "rst_lv");
    expect_in(0, K_THR,   0,      "rst_thr");
    step(2);
    WF_RST_N = 1'b1;
    step(1);

    start = 1'b1;
    expect_in(1, K_STATE, S_IDLE, "idle_ignores_start");
    step(1);
    start = 1'b0;

    // Calibration: peak 5000 on ch5 in the 8th of 16 sets.
    cal_req = 1'b1;
    expect_in(1, K_STATE, S_CAL, "cal_enter");
    expect_in(1, K_CHSEL, 8'hFF, "cal_chsel");
    expect_in(1, K_EN,    1,     "cal_en");
    step(1);
    cal_req = 1'b0;
    peak = 0;
    for (int s = 0; s < 16; s++) begin
      b = '0;
      for (int i = 0; i < NCH; i++) b[i*TW +: TW] = TW'(200 * i + s);
      b[5*TW +: TW] = TW'((s == 7) ? 5000 : 3000 + s);
      peak = (s == 7) ? 5000 : (peak > 3000 + s ? peak : 3000 + s);
      expect_in(1, K_STATE, (s == 15) ? S_ARMED : S_CAL, "cal_state");
      expect_in(1, K_THR, peak, "cal_thresh");
      send(b);
      step(1);
    end

    expect_in(1, K_LV, 0, "armed_blank_lv");
    send(mk(8'h00, 0));

    // Start, centre line at 4995 -> FOLLOW straight.
    start = 1'b1;
    expect_in(1, K_STATE, S_SEEK, "seek_enter");
    step(1);
    start = 1'b0;
    expect_in(0, K_CHSEL, 8'h18, "seek_chsel");
    expect_in(0, K_DRIVE, 3,     "seek_drive");
    expect_in(1, K_SPD_L, 3200,  "seek_spd_l");
    expect_in(1, K_LV,    8'h18, "centre_lv");
    expect_in(2, K_STATE, S_FOLLOW, "follow_enter");
    expect_in(3, K_SPD_L, 3200, "straight_l");
    expect_in(3, K_SPD_R, 3200, "straight_r");
    expect_in(3, K_DIR_L, 0,    "straight_dir_l");
    expect_in(3, K_DIR_R, 0,    "straight_dir_r");
    send(mk(8'h18, 4995));
    step(3);

    // Steering table; ends with err>0 so the search spins left.
    tbl[0] = '{8'h02, 7200, 0};
    tbl[1] = '{8'h20, 800, 5600};
    tbl[2] = '{8'h24, 3200, 3200};
    tbl[3] = '{8'h80, 0, 8000};
    tbl[4] = '{8'h40, 0, 7200};
    prev_l = 3200;
    prev_r = 3200;
    foreach (tbl[k]) begin
      expect_in(1, K_LV,    int'(tbl[k].mask), "steer_lv");
      expect_in(1, K_SPD_L, prev_l,   "steer_l_lat");
      expect_in(1, K_SPD_R, prev_r,   "steer_r_lat");
      expect_in(2, K_SPD_L, tbl[k].l, "steer_l");
      expect_in(2, K_SPD_R, tbl[k].r, "steer_r");
      expect_in(2, K_STATE, S_FOLLOW, "steer_state");
      send(mk(tbl[k].mask, 5200));
      step(2);
      prev_l = tbl[k].l;
      prev_r = tbl[k].r;
    end

    // Line lost -> SEARCH spin, then timeout after 2000 ticks.
    expect_in(1, K_LV,    0, "lost_lv");
    expect_in(2, K_STATE, S_SEARCH, "search_enter");
    expect_in(2, K_DIR_L, 1, "search_dir_l");
    expect_in(2, K_DIR_R, 0, "search_dir_r");
    expect_in(2, K_DRIVE, 3, "search_drive");
    expect_in(3, K_SPD_L, 1600, "search_spd_l");
    expect_in(3, K_SPD_R, 1600, "search_spd_r");
    send(mk(8'h00, 0));
    step(2);
    for (int t = 0; t < 1999; t++) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
    end
    expect_in(0, K_STATE, S_SEARCH, "search_1999");
    tick = 1'b1;
    expect_in(1, K_STATE, S_SEARCH, "search_2000_edge");
    expect_in(2, K_STATE, S_STOP,   "timeout_stop");
    expect_in(2, K_DRIVE, 0,        "timeout_drive");
    expect_in(2, K_EN,    1,        "timeout_en");
    expect_in(3, K_SPD_L, 3200,     "stop_spd_l");
    step(1);
    tick = 1'b0;
    step(3);

    // Restart, then bump in the same cycle the line moves.
    start = 1'b1;
    expect_in(1, K_STATE, S_SEEK, "restart_seek");
    step(1);
    start = 1'b0;
    expect_in(2, K_STATE, S_FOLLOW, "refollow");
    send(mk(8'h18, 4995));
    step(2);
    bump_n = 6'b111011;
    expect_in(1, K_STATE, S_STOP, "bump_stop");
    expect_in(1, K_DRIVE, 0,      "bump_drive");
    expect_in(1, K_LV,    8'h40,  "bump_lv");
    send(mk(8'h40, 5200));
    start = 1'b1;
    expect_in(1, K_STATE, S_STOP, "bumped_start_1");
    expect_in(2, K_STATE, S_STOP, "bumped_start_2");
    expect_in(2, K_SPD_L, 3200,   "bumped_spd_l");
    step(1);
    start = 1'b0;
    step(1);
    bump_n = '1;

    // cal_req beats start; recalibrate with a flat 5000.
    cal_req = 1'b1;
    start   = 1'b1;
    expect_in(1, K_STATE, S_CAL, "cal_beats_start");
    expect_in(1, K_THR,   0,     "recal_clear");
    step(1);
    cal_req = 1'b0;
    start   = 1'b0;
    for (int s = 0; s < 16; s++) begin
      expect_in(1, K_STATE, (s == 15) ? S_ARMED : S_CAL, "recal_state");
      expect_in(1, K_THR, 5000, "recal_thresh");
      send(mk(8'hFF, 5000));
      step(1);
    end
    expect_in(1, K_LV, 0, "rearmed_blank_lv");
    send(mk(8'h00, 0));

    bump_n = 6'b111110;
    start  = 1'b1;
    expect_in(1, K_STATE, S_ARMED, "armed_bumped_start");
    step(1);
    start  = 1'b0;
    bump_n = '1;
    start  = 1'b1;
    expect_in(1, K_STATE, S_SEEK, "armed_start");
    step(1);
    start = 1'b0;

    // Margin boundary: 4989 misses, 4990 exactly meets, 4999 detects.
    b = mk(8'h08, 4989) | mk(8'h10, 4990) | mk(8'h20, 4999);
    expect_in(1, K_LV,    8'h30,    "margin_lv");
    expect_in(2, K_STATE, S_FOLLOW, "margin_follow");
    expect_in(3, K_SPD_L, 1600,     "margin_spd_l");
    expect_in(3, K_SPD_R, 4800,     "margin_spd_r");
    send(b);
    step(3);

    // Asynchronous reset mid-FOLLOW: checked before the next rising edge.
    WF_RST_N = 1'b0;
    expect_in(0, K_STATE, S_IDLE, "arst_state");
    expect_in(0, K_EN,    0,      "arst_en");
    expect_in(0, K_DRIVE, 0,      "arst_drive");
    expect_in(0, K_SPD_L, 0,      "arst_spd_l");
    expect_in(0, K_SPD_R, 0,      "arst_spd_r");
    expect_in(0, K_CHSEL, 0,      "arst_chsel");
    expect_in(0, K_LV,    0,      "arst_lv");
    expect_in(0, K_THR,   0,      "arst_thr");
    step(2);
    WF_RST_N = 1'b1;
    step(1);
    start = 1'b1;
    expect_in(1, K_STATE, S_IDLE, "post_rst_needs_cal");
    step(1);
    start = 1'b0;
    step(3);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
